if_fetch_unit: RTL and testbench

- Instruction fetch stage of the single-cycle/pipelined core, directly upstream of the instruction memory.
- Owns the fetch PC and drives the memory's byte address. The memory returns a 32-bit big-endian-assembled word combinationally in the same cycle.
- Captures {pc, instr} pairs into a small in-order queue and presents them to decode through a valid/ready handshake.
- Supports branch/jump redirect with queue flush.

---
 rtl/if_fetch_unit_if.sv | 51 +++++
 rtl/if_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles the fetch unit's memory-side and decode-side signals.
//   master : the fetch unit (drives instr_addr and the out_* head fields)
//   slave  : the environment (instruction memory, branch unit, decode)
// Signals:
//   instr_addr     fetch byte address to instruction memory
//   instr_in       word returned by memory for instr_addr, same cycle
//   redirect_valid branch/jump taken
//   redirect_pc    redirect target byte address
//   out_valid      queue head holds a valid instruction
//   out_ready      decode accepts the head this cycle
//   out_instr      instruction at queue head
//   out_pc         byte address of out_instr
//   fetch_misalign misaligned redirect target flag
// ----------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic [31:0] instr_addr;
    logic [31:0] instr_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_misalign;

    modport master (
        output instr_addr,
        output out_valid,
        output out_instr,
        output out_pc,
        output fetch_misalign,
        input  instr_in,
        input  redirect_valid,
        input  redirect_pc,
        input  out_ready
    );

    modport slave (
        input  instr_addr,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  fetch_misalign,
        output instr_in,
        output redirect_valid,
        output redirect_pc,
        output out_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: owns the fetch PC, drives the instruction memory
// address, captures {pc, instr} pairs into a small in-order queue and hands
// them to decode over a valid/ready handshake. A redirect flushes the queue
// and reloads the PC (aligned to a word).
//
// Ports:
//   clk  core clock, rising edge
//   rst  asynchronous active-high reset
//   bus  if_fetch_unit_if.master (memory address/data, redirect, decode side)
//
// Parameters:
//   RESET_PC  fetch PC loaded on reset
//   DEPTH     queue entries; power of two, >= 2
//
// Optional feature macro: IF_FETCH_MISALIGN_CHK_EN
//   When defined, a redirect to a non word-aligned target raises
//   fetch_misalign and stalls fetch until the next aligned redirect.
//   When undefined, fetch_misalign is tied to 0 and redirect_pc[1:0] ignored.
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_unit_if.master  bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     fetch_pc;
    logic            out_valid_q;
    entry_t          head_q;

    logic [PW-1:0]   rd_ptr_nxt;
    logic [PW-1:0]   wr_ptr_nxt;
    logic [CW-1:0]   count_nxt;
    logic [31:0]     fetch_pc_nxt;
    logic            out_valid_nxt;
    entry_t          head_nxt;

    logic            pop_c;
    logic            push_ok_c;
    logic            push_c;
    logic            stall_c;

`ifdef IF_FETCH_MISALIGN_CHK_EN
    logic            misalign_q;
    logic            misalign_nxt;

    // Sticky until the next redirect re-evaluates the target alignment.
    always_comb begin
        misalign_nxt = misalign_q;
        if (bus.redirect_valid) begin
            misalign_nxt = |bus.redirect_pc[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_nxt;
        end
    end

    assign stall_c            = misalign_q;
    assign bus.fetch_misalign = misalign_q;
`else
    assign stall_c            = 1'b0;
    assign bus.fetch_misalign = 1'b0;
`endif

    // Handshake qualification: a redirect overrides both push and pop.
    always_comb begin
        pop_c     = out_valid_q & bus.out_ready & ~bus.redirect_valid;
        push_ok_c = (count < CW'(DEPTH)) | pop_c;
        push_c    = ~bus.redirect_valid & ~stall_c & push_ok_c;
    end

    // Next-state for pointers, occupancy, PC and the registered head view.
    always_comb begin
        rd_ptr_nxt    = rd_ptr;
        wr_ptr_nxt    = wr_ptr;
        count_nxt     = count;
        fetch_pc_nxt  = fetch_pc;
        out_valid_nxt = 1'b0;
        head_nxt      = head_q;

        if (bus.redirect_valid) begin
            rd_ptr_nxt   = '0;
            wr_ptr_nxt   = '0;
            count_nxt    = '0;
            fetch_pc_nxt = bus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (pop_c) begin
                rd_ptr_nxt = rd_ptr + PW'(1);
            end
            if (push_c) begin
                wr_ptr_nxt   = wr_ptr + PW'(1);
                fetch_pc_nxt = fetch_pc + 32'd4;
            end
            case ({push_c, pop_c})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase

            out_valid_nxt = (count_nxt != '0);

            // The new head is the word being fetched now if the queue drains
            // to empty before this push; otherwise it is already stored.
            if (out_valid_nxt) begin
                if (count == CW'(pop_c)) begin
                    head_nxt = '{pc: fetch_pc, instr: bus.instr_in};
                end else begin
                    head_nxt = mem[rd_ptr_nxt];
                end
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_pc    <= RESET_PC;
            out_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            rd_ptr      <= rd_ptr_nxt;
            wr_ptr      <= wr_ptr_nxt;
            count       <= count_nxt;
            fetch_pc    <= fetch_pc_nxt;
            out_valid_q <= out_valid_nxt;
            head_q      <= head_nxt;
        end
    end

    // Queue storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push_c) begin
            mem[wr_ptr] <= '{pc: fetch_pc, instr: bus.instr_in};
        end
    end

    assign bus.instr_addr = fetch_pc;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc     = head_q.pc;
    assign bus.out_instr  = head_q.instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam int DEPTH = 2;
`ifdef IF_FETCH_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: word at 0 is 32'h00500093.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    assign bus.instr_in = mem_word(bus.instr_addr);

    // Reference model: a plain FIFO of {pc, instr} plus the fetch PC.
    logic [31:0] m_pc;
    logic        m_mis;
    logic [63:0] m_q[$];

    task automatic model_reset();
        m_q.delete();
        m_pc  = 32'h0;
        m_mis = 1'b0;
    endtask

    task automatic model_edge();
        int sz;
        bit pop;
        if (bus.redirect_valid) begin
            m_q.delete();
            m_pc  = bus.redirect_pc & 32'hFFFF_FFFC;
            m_mis = MIS_EN && (bus.redirect_pc[1:0] != 2'b00);
        end else begin
            sz  = m_q.size();
            pop = (sz > 0) && bus.out_ready;
            if (pop) void'(m_q.pop_front());
            if (((sz < DEPTH) || pop) && !m_mis) begin
                m_q.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [63:0] head;
        check("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
        check("instr_addr", bus.instr_addr, m_pc);
        check("fetch_misalign", 32'(bus.fetch_misalign), 32'(m_mis));
        check("count", 32'(dut.count), 32'(m_q.size()));
        if (m_q.size() != 0) begin
            head = m_q[0];
            check("out_pc", bus.out_pc, head[63:32]);
            check("out_instr", bus.out_instr, head[31:0]);
        end
    endtask

    // One clock: model consumes the inputs present before the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic redirect_step(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
    endtask

    initial begin
        logic [31:0] tgt;
        checks = 0;
        errors = 0;
        rst                = 1'b1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        model_reset();

        // Reset state
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_instr_addr", bus.instr_addr, 32'h0);
        check("rst_misalign", 32'(bus.fetch_misalign), 32'h0);
        rst = 1'b0;

        // Sequential fetch
        bus.out_ready = 1'b1;
        step();
        check("seq_first_valid", 32'(bus.out_valid), 32'h1);
        check("seq_first_pc", bus.out_pc, 32'h0);
        check("seq_first_instr", bus.out_instr, 32'h0050_0093);
        step();
        check("seq_second_pc", bus.out_pc, 32'h4);
        step();
        step();
        check("seq_fourth_pc", bus.out_pc, 32'hC);

        // Async reset between edges while out_valid=1
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_out_valid", 32'(bus.out_valid), 32'h0);
        check("arst_instr_addr", bus.instr_addr, 32'h0);
        check("arst_count", 32'(dut.count), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Backpressure
        bus.out_ready = 1'b0;
        repeat (5) step();
        check("bp_count", 32'(dut.count), 32'h2);
        check("bp_addr_frozen", bus.instr_addr, 32'h8);
        check("bp_head_pc", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        step();
        check("bp_release_pc1", bus.out_pc, 32'h4);
        step();
        check("bp_release_pc2", bus.out_pc, 32'h8);

        // Redirect with a full queue
        bus.out_ready = 1'b0;
        step();
        step();
        check("full_before_redirect", 32'(dut.count), 32'h2);
        bus.out_ready = 1'b1;
        redirect_step(32'h40);
        check("redir_valid_low", 32'(bus.out_valid), 32'h0);
        check("redir_addr", bus.instr_addr, 32'h40);
        step();
        check("redir_target_valid", 32'(bus.out_valid), 32'h1);
        check("redir_target_pc", bus.out_pc, 32'h40);

        // Back-to-back redirects: last one wins
        redirect_step(32'h100);
        redirect_step(32'h200);
        step();
        check("b2b_target_pc", bus.out_pc, 32'h200);

        // Wrap-around
        redirect_step(32'hFFFF_FFF8);
        step();
        check("wrap_pc0", bus.out_pc, 32'hFFFF_FFF8);
        step();
        check("wrap_pc1", bus.out_pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc2", bus.out_pc, 32'h0000_0000);

        // Misaligned redirect target
        redirect_step(32'h22);
        check("mis_addr", bus.instr_addr, 32'h20);
        check("mis_flag", 32'(bus.fetch_misalign), 32'(MIS_EN));
        step();
        if (MIS_EN) begin
            check("mis_stuck_valid", 32'(bus.out_valid), 32'h0);
            check("mis_stuck_addr", bus.instr_addr, 32'h20);
        end else begin
            check("nomis_valid", 32'(bus.out_valid), 32'h1);
            check("nomis_pc", bus.out_pc, 32'h20);
        end
        step();
        redirect_step(32'h30);
        check("mis_cleared", 32'(bus.fetch_misalign), 32'h0);
        step();
        check("mis_recover_pc", bus.out_pc, 32'h30);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0:       tgt = $urandom;
                    1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                    default: tgt = $urandom & 32'hFF;
                endcase
                if ($urandom_range(0, 3) != 0) tgt = tgt & 32'hFFFF_FFFC;
                redirect_step(tgt);
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
